logic_unit_seq: RTL and testbench

Parametrised, slice-serial bitwise logic unit for the ALU element library. It generalises the fixed 32-bit single-function gates to a configurable `WIDTH` and eight selectable bitwise operations. It processes `SLICE` bits per clock under a start/done handshake, so wide operands can share narrow logic. It sits beside the ALU elements and is driven by the multi-cycle datapath controller.

---
 rtl/logic_unit_seq.sv | 114 +++++++++++
 tb/tb_logic_unit_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Slice-serial bitwise logic unit: eight selectable operations, SLICE bits per clock,
// with a start/done handshake around a three-state controller.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - SLICE);

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, wrk, wrk_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic [31:0]      base;
    logic [SLICE-1:0] sa, sb, sr;
    logic             last, accept;

    // Handshake: start is sampled at a rising edge in IDLE or DONE (ignored in BUSY);
    // done is a one-cycle pulse in the cycle after the final slice, with res/zero valid.
    assign last   = (cnt == CW'(N - 1));
    assign accept = start && (state != BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only the slice addressed by cnt is evaluated; the rest of wrk is carried over.
    always_comb begin
        base = 32'(cnt) * 32'(SLICE);
        a_sh = a_q >> base;
        b_sh = b_q >> base;
        sa   = a_sh[SLICE-1:0];
        sb   = b_sh[SLICE-1:0];
        case (op_q)
            3'b000:  sr = sa & sb;
            3'b001:  sr = sa | sb;
            3'b010:  sr = sa ^ sb;
            3'b011:  sr = ~(sa | sb);
            3'b100:  sr = ~(sa & sb);
            3'b101:  sr = ~(sa ^ sb);
            3'b110:  sr = sa & ~sb;
            default: sr = sa;
        endcase
        wrk_nxt = (wrk & ~(SLICE_MASK << base)) | (WIDTH'(sr) << base);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            wrk  <= '0;
            cnt  <= '0;
            res  <= '0;
            zero <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
                cnt  <= '0;
            end
            if (state == BUSY) begin
                wrk <= wrk_nxt;
                cnt <= cnt + 1'b1;
                if (last) begin
                    res  <= wrk_nxt;
                    zero <= (wrk_nxt == '0);
                end
            end
        end
    end

    assign busy      = (state == BUSY);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: vector table, randomized ops against a truth-table model,
// and hand-written sequences for busy-start, back-to-back, mid-op reset and N=1.
module tb_logic_unit_seq;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start, zero, busy, done;
    logic [2:0]  op;
    logic [31:0] a_in, b_in, res;
    logic [1:0]  dbg;

    logic        start_w, zero_w, busy_w, done_w;
    logic [2:0]  op_w;
    logic [63:0] a_w, b_w, res_w;
    logic [1:0]  dbg_w;

    logic_unit_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a_in), .B(b_in),
        .res(res), .zero(zero), .busy(busy), .done(done), .dbg_state(dbg)
    );

    logic_unit_seq #(.WIDTH(64), .SLICE(64)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .op(op_w), .A(a_w), .B(b_w),
        .res(res_w), .zero(zero_w), .busy(busy_w), .done(done_w), .dbg_state(dbg_w)
    );

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: each result bit looked up in the operation's 2-input truth table,
    // indexed by {a_bit, b_bit}.
    function automatic logic [3:0] truth_table(input logic [2:0] o);
        case (o)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0110;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0111;
            3'd5:    return 4'b1001;
            3'd6:    return 4'b0100;
            default: return 4'b1100;
        endcase
    endfunction

    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
        logic [3:0]  tt;
        logic [63:0] r;
        tt = truth_table(o);
        r  = '0;
        for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    // driver: one operation with a single-cycle start on the 32-bit instance
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z);
        int lat, nbusy;
        logic stable;
        logic [31:0] prev_res;
        logic [63:0] e;
        exp_q.push_back({32'd0, exp_r});
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); a_in = $urandom; b_in = $urandom;
        prev_res = res; stable = 1'b1; lat = 0; nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            if (res !== prev_res) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, " done latency"}, 64'(lat), 64'd4);
        check({tag, " busy cycles"}, 64'(nbusy), 64'd4);
        check({tag, " res held while busy"}, 64'(stable), 64'd1);
        e = exp_q.pop_front();
        check({tag, " res"}, 64'(res), e);
        check({tag, " zero"}, 64'(zero), 64'(exp_z));
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(done), 64'd0);
    endtask

    task automatic run_wide(input string tag, input logic [2:0] o, input logic [63:0] a,
                            input logic [63:0] b);
        int lat;
        logic [63:0] e;
        e = model(o, a, b, 64);
        op_w = o; a_w = a; b_w = b; start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0; a_w = {$urandom, $urandom};
        check({tag, " busy after accept"}, 64'(busy_w), 64'd1);
        lat = 0;
        while (!done_w && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " done latency"}, 64'(lat), 64'd1);
        check({tag, " res"}, res_w, e);
        check({tag, " zero"}, 64'(zero_w), 64'(e == 64'd0));
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, nbusy, ndone;
        logic [31:0] got, ra, rb, e32;
        logic [2:0]  ro;

        vecs[0] = '{3'b011, 32'hF0F00000, 32'h0F0F00FF, 32'h0000FF00, 1'b0};
        vecs[1] = '{3'b010, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1};
        vecs[2] = '{3'b000, 32'hFFFF0000, 32'h0FF00FF0, 32'h0FF00000, 1'b0};
        vecs[3] = '{3'b001, 32'hF0F00000, 32'h0F0F00FF, 32'hFFFF00FF, 1'b0};
        vecs[4] = '{3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[5] = '{3'b101, 32'h0000FFFF, 32'h00FF00FF, 32'hFF0000FF, 1'b0};
        vecs[6] = '{3'b110, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000, 1'b0};
        vecs[7] = '{3'b111, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        start_w = 1'b0; op_w = '0; a_w = '0; b_w = '0;
        #12;
        check("reset res", 64'(res), 64'd0);
        check("reset zero", 64'(zero), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset state", 64'(dbg), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_res, vecs[i].exp_zero);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            e32 = model(ro, {32'd0, ra}, {32'd0, rb}, 32);
            run_op($sformatf("rand%0d", i), ro, ra, rb, e32, e32 == 32'd0);
        end

        // start pulsed during BUSY is ignored
        op = 3'b000; a_in = 32'hFFFF0000; b_in = 32'h0FF00FF0; start = 1'b1;
        nbusy = 0; ndone = 0; got = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin ndone++; got = res; end
            if (i == 0) start = 1'b0;
            if (i == 1) begin start = 1'b1; op = 3'b001; a_in = 32'h12345678; b_in = 32'h0; end
            if (i == 2) start = 1'b0;
        end
        check("busy-start done count", 64'(ndone), 64'd1);
        check("busy-start busy cycles", 64'(nbusy), 64'd4);
        check("busy-start res", 64'(got), 64'h0FF00000);

        // back-to-back with start held through DONE
        op = 3'b000; a_in = 32'hFFFF0000; b_in = 32'h0FF00FF0; start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        check("b2b first latency", 64'(lat), 64'd4);
        check("b2b first res", 64'(res), 64'h0FF00000);
        op = 3'b111; a_in = 32'hDEADBEEF; b_in = $urandom;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy reassert", 64'(busy), 64'd1);
        check("b2b done dropped", 64'(done), 64'd0);
        lat = 0; nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check("b2b second latency", 64'(lat), 64'd4);
        check("b2b second busy cycles", 64'(nbusy), 64'd4);
        check("b2b second res", 64'(res), 64'hDEADBEEF);
        @(negedge clk);

        // asynchronous reset two cycles into BUSY
        op = 3'b001; a_in = 32'h00F0000F; b_in = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset res", 64'(res), 64'd0);
        check("midreset zero", 64'(zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset no done after release", 64'(ndone), 64'd0);
        check("midreset res after release", 64'(res), 64'd0);

        // N = 1 instance
        run_wide("wide nand ones", 3'b100, {64{1'b1}}, {64{1'b1}});
        check("wide nand zero flag", 64'(zero_w), 64'd1);
        for (int i = 0; i < 6; i++)
            run_wide($sformatf("wide rand%0d", i), 3'($urandom_range(0, 7)),
                     {$urandom, $urandom}, {$urandom, $urandom});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
